// File: rtl/gpt_pkg.sv
// Shared types and helpers for the general-purpose timer capture channel.
package gpt_pkg;

    localparam int unsigned EV_W = 3;

    typedef enum logic [1:0] {
        ICPS_1 = 2'b00,
        ICPS_2 = 2'b01,
        ICPS_4 = 2'b10,
        ICPS_8 = 2'b11
    } icps_e;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_NONE = 2'b11
    } edge_sel_e;

    typedef enum logic [1:0] {
        CAP_IDLE     = 2'b00,
        CAP_ARMED    = 2'b01,
        CAP_CAPTURED = 2'b10,
        CAP_OVER     = 2'b11
    } cap_state_e;

    // Terminal event count (N-1) for a given prescale setting.
    function automatic logic [EV_W-1:0] icps_to_n(input icps_e icps);
        logic [EV_W-1:0] r;
        case (icps)
            ICPS_1:  r = EV_W'(0);
            ICPS_2:  r = EV_W'(1);
            ICPS_4:  r = EV_W'(3);
            default: r = EV_W'(7);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gpt_edge_detect.sv
// Capture pin synchronizer, edge history and edge-select decode.
module gpt_edge_detect
    import gpt_pkg::*;
(
    input  logic       clk_i,
    input  logic       aresetn_i,
    input  logic       ic_i,
    input  logic [1:0] edge_sel_i,
    output logic       evt_c
);

    logic s1_q;
    logic s2_q;
    logic s3_q;
    logic rise_c;
    logic fall_c;

    // Two-flop synchronizer followed by a history flop for edge detection.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= ic_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_c = s2_q & ~s3_q;
    assign fall_c = ~s2_q & s3_q;

    // Qualify the detected edge against the selected polarity.
    always_comb begin
        evt_c = 1'b0;
        case (edge_sel_e'(edge_sel_i))
            EDGE_RISE: evt_c = rise_c;
            EDGE_FALL: evt_c = fall_c;
            EDGE_BOTH: evt_c = rise_c | fall_c;
            default:   evt_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/gpt_capture_ctrl.sv
// Input-capture channel: prescaled edge capture of the timer count with read handshake.
module gpt_capture_ctrl
    import gpt_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             aresetn_i,
    input  logic             cce_i,
    input  logic [1:0]       icps_i,
    input  logic [1:0]       edge_sel_i,
    input  logic             ic_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             rd_i,
    output logic [CNT_W-1:0] ccr_o,
    output logic             ccif_o,
    output logic             ovc_o,
    output logic             irq_o
);

    logic            evt_c;
    logic            cap_c;
    logic            cfg_chg_c;
    logic [1:0]      icps_q;
    logic [1:0]      edge_sel_q;
    logic [EV_W-1:0] ev_cnt_q;

    cap_state_e       state_q;
    cap_state_e       state_d;
    cap_state_e       eff_state_c;
    logic [CNT_W-1:0] ccr_d;
    logic             ccif_d;
    logic             ovc_d;
    logic             irq_d;

    gpt_edge_detect u_edge_detect (
        .clk_i      (clk_i),
        .aresetn_i  (aresetn_i),
        .ic_i       (ic_i),
        .edge_sel_i (edge_sel_i),
        .evt_c      (evt_c)
    );

    assign cfg_chg_c = (icps_i != icps_q) || (edge_sel_i != edge_sel_q);
    assign cap_c     = cce_i && evt_c && (ev_cnt_q == icps_to_n(icps_e'(icps_i)));

    // Prescale event counter; restarts on disable or any configuration change.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            icps_q     <= 2'b00;
            edge_sel_q <= 2'b00;
            ev_cnt_q   <= '0;
        end else begin
            icps_q     <= icps_i;
            edge_sel_q <= edge_sel_i;
            if (!cce_i || cfg_chg_c) begin
                ev_cnt_q <= '0;
            end else if (evt_c) begin
                ev_cnt_q <= cap_c ? '0 : ev_cnt_q + EV_W'(1);
            end
        end
    end

    // State, capture register and flag registers.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q <= CAP_IDLE;
            ccr_o   <= '0;
            ccif_o  <= 1'b0;
            ovc_o   <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            ccr_o   <= ccr_d;
            ccif_o  <= ccif_d;
            ovc_o   <= ovc_d;
            irq_o   <= irq_d;
        end
    end

    // Next state and flags; on re-enable the flags pick the resume state, a capture beats a read.
    always_comb begin
        state_d     = state_q;
        ccr_d       = ccr_o;
        ccif_d      = ccif_o;
        ovc_d       = ovc_o;
        irq_d       = 1'b0;
        eff_state_c = state_q;

        if (state_q == CAP_IDLE) begin
            eff_state_c = ccif_o ? (ovc_o ? CAP_OVER : CAP_CAPTURED) : CAP_ARMED;
        end

        if (!cce_i) begin
            state_d = CAP_IDLE;
            if (rd_i) begin
                ccif_d = 1'b0;
                ovc_d  = 1'b0;
            end
        end else if (cap_c) begin
            ccr_d  = cnt_i;
            irq_d  = 1'b1;
            ccif_d = 1'b1;
            if ((eff_state_c == CAP_ARMED) || rd_i) begin
                state_d = CAP_CAPTURED;
                ovc_d   = 1'b0;
            end else begin
                state_d = CAP_OVER;
                ovc_d   = 1'b1;
            end
        end else if (rd_i) begin
            state_d = CAP_ARMED;
            ccif_d  = 1'b0;
            ovc_d   = 1'b0;
        end else begin
            state_d = eff_state_c;
        end
    end

endmodule

// File: tb/tb_gpt_capture_ctrl.sv
// Directed bench for gpt_capture_ctrl with a capture scoreboard.
module tb_gpt_capture_ctrl;

    logic        clk = 1'b0;
    logic        aresetn_i;
    logic        cce_i;
    logic [1:0]  icps_i;
    logic [1:0]  edge_sel_i;
    logic        ic_i;
    logic [15:0] cnt_i;
    logic        rd_i;
    logic [15:0] ccr_o;
    logic        ccif_o;
    logic        ovc_o;
    logic        irq_o;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    gpt_capture_ctrl #(.CNT_W(16)) dut (
        .clk_i      (clk),
        .aresetn_i  (aresetn_i),
        .cce_i      (cce_i),
        .icps_i     (icps_i),
        .edge_sel_i (edge_sel_i),
        .ic_i       (ic_i),
        .cnt_i      (cnt_i),
        .rd_i       (rd_i),
        .ccr_o      (ccr_o),
        .ccif_o     (ccif_o),
        .ovc_o      (ovc_o),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one pin level change and let it propagate through to the capture edge.
    task automatic set_pin(input logic v, input logic [15:0] c, input bit expect_cap);
        ic_i  = v;
        cnt_i = c;
        if (expect_cap) exp_q.push_back(c);
        tick(3);
    endtask

    // One full high pulse: rising then falling.
    task automatic pulse(input logic [15:0] c, input bit expect_cap);
        set_pin(1'b1, c, expect_cap);
        set_pin(1'b0, c, 1'b0);
    endtask

    task automatic read_pulse();
        rd_i = 1'b1;
        tick(1);
        rd_i = 1'b0;
    endtask

    // Scoreboard: every irq pulse must match the oldest expected capture.
    always @(negedge clk) begin
        if (irq_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_irq", 32'(irq_o), 32'd0);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("sb_ccr", 32'(ccr_o), 32'(e));
            end
        end
    end

    initial begin
        aresetn_i  = 1'b0;
        cce_i      = 1'b0;
        icps_i     = 2'b00;
        edge_sel_i = 2'b00;
        ic_i       = 1'b0;
        cnt_i      = 16'h0000;
        rd_i       = 1'b0;
        tick(2);
        chk("rst_ccr",  32'(ccr_o),  32'd0);
        chk("rst_ccif", 32'(ccif_o), 32'd0);
        chk("rst_ovc",  32'(ovc_o),  32'd0);
        chk("rst_irq",  32'(irq_o),  32'd0);
        aresetn_i = 1'b1;
        tick(2);

        // Basic capture, rising edge, no prescale.
        cce_i = 1'b1;
        tick(2);
        ic_i  = 1'b1;
        cnt_i = 16'h1234;
        exp_q.push_back(16'h1234);
        tick(2);
        chk("basic_irq_early", 32'(irq_o), 32'd0);
        tick(1);
        chk("basic_irq",  32'(irq_o),  32'd1);
        chk("basic_ccr",  32'(ccr_o),  32'h1234);
        chk("basic_ccif", 32'(ccif_o), 32'd1);
        chk("basic_ovc",  32'(ovc_o),  32'd0);
        tick(1);
        chk("basic_irq_one_cycle", 32'(irq_o), 32'd0);
        read_pulse();
        chk("basic_rd_ccif", 32'(ccif_o), 32'd0);
        set_pin(1'b0, 16'h1235, 1'b0);

        // Prescale by 4 on both edges: captures on the 4th and 8th toggle.
        icps_i     = 2'b10;
        edge_sel_i = 2'b10;
        tick(2);
        for (int i = 0; i < 8; i++) begin
            set_pin(~ic_i, 16'h0100 + 16'(i), (i == 3) || (i == 7));
        end
        chk("ps4_ccr", 32'(ccr_o), 32'h0107);
        chk("ps4_ovc", 32'(ovc_o), 32'd1);
        read_pulse();
        chk("ps4_rd_ccif", 32'(ccif_o), 32'd0);
        chk("ps4_rd_ovc",  32'(ovc_o),  32'd0);

        // Overcapture, rising edges only.
        icps_i     = 2'b00;
        edge_sel_i = 2'b00;
        tick(2);
        pulse(16'h0010, 1'b1);
        pulse(16'h0020, 1'b1);
        chk("ovc_ccr",  32'(ccr_o),  32'h0020);
        chk("ovc_ccif", 32'(ccif_o), 32'd1);
        chk("ovc_ovc",  32'(ovc_o),  32'd1);
        read_pulse();
        chk("ovc_rd_ccif", 32'(ccif_o), 32'd0);
        chk("ovc_rd_ovc",  32'(ovc_o),  32'd0);

        // Capture and read on the same edge while CAPTURED.
        pulse(16'h0030, 1'b1);
        ic_i  = 1'b1;
        cnt_i = 16'h0040;
        exp_q.push_back(16'h0040);
        tick(2);
        rd_i = 1'b1;
        tick(1);
        rd_i = 1'b0;
        chk("sim_ccr",  32'(ccr_o),  32'h0040);
        chk("sim_ccif", 32'(ccif_o), 32'd1);
        chk("sim_ovc",  32'(ovc_o),  32'd0);
        tick(1);
        set_pin(1'b0, 16'h0040, 1'b0);
        pulse(16'h0050, 1'b1);
        chk("sim_next_ovc", 32'(ovc_o), 32'd1);
        read_pulse();

        // Disable mid-prescale with a pending flag, then re-enable.
        pulse(16'h0060, 1'b1);
        icps_i = 2'b11;
        tick(2);
        for (int i = 0; i < 5; i++) pulse(16'h0061 + 16'(i), 1'b0);
        cce_i = 1'b0;
        tick(2);
        pulse(16'h0066, 1'b0);
        chk("dis_ccif_held", 32'(ccif_o), 32'd1);
        chk("dis_ccr_held",  32'(ccr_o),  32'h0060);
        cce_i = 1'b1;
        tick(1);
        for (int i = 0; i < 8; i++) pulse(16'h0070 + 16'(i), i == 7);
        chk("reen_ccr", 32'(ccr_o), 32'h0077);
        chk("reen_ovc", 32'(ovc_o), 32'd1);
        cce_i = 1'b0;
        tick(1);
        read_pulse();
        chk("idle_rd_ccif", 32'(ccif_o), 32'd0);
        chk("idle_rd_ovc",  32'(ovc_o),  32'd0);
        chk("idle_rd_ccr",  32'(ccr_o),  32'h0077);

        // Reset while in OVER with an edge still in the synchronizer.
        cce_i  = 1'b1;
        icps_i = 2'b00;
        tick(2);
        pulse(16'h0080, 1'b1);
        pulse(16'h0090, 1'b1);
        chk("pre_rst_ovc", 32'(ovc_o), 32'd1);
        ic_i  = 1'b1;
        cnt_i = 16'h00EE;
        tick(1);
        ic_i      = 1'b0;
        aresetn_i = 1'b0;
        #2;
        chk("async_rst_ccr",  32'(ccr_o),  32'd0);
        chk("async_rst_ccif", 32'(ccif_o), 32'd0);
        chk("async_rst_ovc",  32'(ovc_o),  32'd0);
        chk("async_rst_irq",  32'(irq_o),  32'd0);
        tick(1);
        aresetn_i = 1'b1;
        tick(5);
        chk("post_rst_ccr",  32'(ccr_o),  32'd0);
        chk("post_rst_ccif", 32'(ccif_o), 32'd0);
        pulse(16'h00A0, 1'b1);
        chk("post_rst_cap_ccr",  32'(ccr_o),  32'h00A0);
        chk("post_rst_cap_ccif", 32'(ccif_o), 32'd1);
        chk("post_rst_cap_ovc",  32'(ovc_o),  32'd0);

        tick(2);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
